// File: rtl/alu_nibble_seq_if.sv
// Request/response bus of the nibble-serial ALU sequencer.
// master = requester (register file side), slave = sequencer.
interface alu_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op_s;
  logic             op_m;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, op_s, op_m, op_a, op_b, carry_in,
    input  busy, done, result, carry_out, zero, overflow
  );

  modport slave (
    input  start, op_s, op_m, op_a, op_b, carry_in,
    output busy, done, result, carry_out, zero, overflow
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer around one 4-bit 74181-style ALU slice.
// Latches an op, feeds the slice one nibble per clock (LSB first), rippling
// carry through carry_reg, then pulses done with result/flags.
// Optional macro ALU_SEQ_OVERFLOW_EN: signed overflow for add/subtract;
// when undefined the overflow output is tied 0.
module alu_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  alu_nibble_seq_if.slave bus,
  output logic [3:0]     alu_s,
  output logic           alu_m,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  output logic           alu_cn,
  input  logic [3:0]     alu_f,
  input  logic           alu_cn4
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [3:0]       s;
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [IDXW-1:0]  idx;
  logic             carry_reg;

  logic [WIDTH-1:0] nxt_res;
  logic             carry_nxt;
  logic [IDXW-1:0]  nxt_idx;
  logic             last;

  // Result with the current slice output merged in, and the carry it produces
  always_comb begin
    nxt_res            = bus.result;
    nxt_res[4*idx +: 4] = alu_f;
    carry_nxt          = op_q.m ? 1'b0 : ~alu_cn4;
    nxt_idx            = idx + 1'b1;
    last               = (idx == IDXW'(NIB - 1));
  end

  // Control FSM; every slice input and status output is a register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      idx           <= '0;
      carry_reg     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.carry_out <= 1'b0;
      bus.zero      <= 1'b0;
      alu_s         <= 4'd0;
      alu_m         <= 1'b1;
      alu_a         <= 4'd0;
      alu_b         <= 4'd0;
      alu_cn        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q.s    <= bus.op_s;
            op_q.m    <= bus.op_m;
            op_q.a    <= bus.op_a;
            op_q.b    <= bus.op_b;
            carry_reg <= bus.carry_in;
            idx       <= '0;
            bus.busy  <= 1'b1;
            state     <= RUN;
            // Present nibble 0 to the slice in the first RUN cycle
            alu_s     <= bus.op_s;
            alu_m     <= bus.op_m;
            alu_a     <= bus.op_a[3:0];
            alu_b     <= bus.op_b[3:0];
            alu_cn    <= ~bus.carry_in;
          end
        end
        RUN: begin
          bus.result <= nxt_res;
          carry_reg  <= carry_nxt;
          idx        <= nxt_idx;
          if (last) begin
            // Flags come from the merged final result so they are valid with done
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.carry_out <= carry_nxt;
            bus.zero      <= (nxt_res == '0);
            alu_s         <= 4'd0;
            alu_m         <= 1'b1;
            alu_a         <= 4'd0;
            alu_b         <= 4'd0;
            alu_cn        <= 1'b1;
          end else begin
            alu_a  <= op_q.a[4*nxt_idx +: 4];
            alu_b  <= op_q.b[4*nxt_idx +: 4];
            alu_cn <= ~carry_nxt;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  logic [WIDTH-1:0] b_eff;
  logic             is_addsub;
  logic             ovf_nxt;

  // Two's-complement overflow: operands agree in sign, result does not
  always_comb begin
    b_eff     = (op_q.s == 4'b0110) ? ~op_q.b : op_q.b;
    is_addsub = ~op_q.m && ((op_q.s == 4'b1001) || (op_q.s == 4'b0110));
    ovf_nxt   = is_addsub && (op_q.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (nxt_res[WIDTH-1] != op_q.a[WIDTH-1]);
  end

  // Overflow flag register, updated alongside the other flags
  always_ff @(posedge clk) begin
    if (rst)
      bus.overflow <= 1'b0;
    else if (state == RUN && last)
      bus.overflow <= ovf_nxt;
  end
`else
  assign bus.overflow = 1'b0;
`endif

endmodule
